// File: rtl/rw_svm_pkg.sv
// Shared constants, state encoding and score clamp for the sequential SVM evaluator.
package rw_svm_pkg;

  localparam int unsigned NUM_A    = 11;
  localparam int unsigned WIDTH_A  = 4;
  localparam int unsigned COEF_W   = 8;
  localparam int unsigned OUTWIDTH = 14;
  localparam int unsigned CFG_AW   = 4;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned PROD_W   = COEF_W + WIDTH_A + 1;
  localparam int unsigned ACC_W    = COEF_W + WIDTH_A + 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUTWIDTH) - 1);

  // Saturate a signed accumulator into the unsigned result range.
  function automatic logic [OUTWIDTH-1:0] clamp(input logic signed [ACC_W-1:0] a);
    logic [OUTWIDTH-1:0] r;
    if (a[ACC_W-1]) begin
      r = '0;
    end else if (a > OUT_MAX) begin
      r = '1;
    end else begin
      r = a[OUTWIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rw_svm_mac.sv
// Single shared multiply-accumulate: signed coefficient x zero-extended feature.
module rw_svm_mac
  import rw_svm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic                      add_i,
  input  logic                      add_bias_i,
  input  logic signed [COEF_W-1:0]  coef_i,
  input  logic        [WIDTH_A-1:0] feat_i,
  input  logic signed [COEF_W-1:0]  bias_i,
  output logic signed [ACC_W-1:0]   acc_next_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Product and accumulator update; load restarts the sum for a new vector.
  always_comb begin
    prod  = PROD_W'(coef_i) * PROD_W'(signed'({1'b0, feat_i}));
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACC_W'(prod);
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end else if (add_bias_i) begin
      acc_d = acc_q + ACC_W'(bias_i);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/rw_svm_seq_ctrl.sv
// Sequential SVM evaluator: feature beats in, one MAC, bias add, clamped score out.
module rw_svm_seq_ctrl
  import rw_svm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH_A-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTWIDTH-1:0] out_data,
  input  logic                cfg_we,
  input  logic [CFG_AW-1:0]   cfg_addr,
  input  logic [COEF_W-1:0]   cfg_data,
  output logic                cfg_err,
  output logic                busy
);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUTWIDTH-1:0]        out_data_q, out_data_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       busy_q, busy_d;
  logic                       load_c, add_c, add_bias_c;
  logic                       accept_c, cfg_hit_c;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [COEF_W-1:0]   coef_q [NUM_A+1];

  assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == ACC));
  assign accept_c  = in_valid && in_ready;
  assign cfg_hit_c = cfg_we && (cfg_addr <= CFG_AW'(NUM_A));

  // Next-state, MAC controls and registered-output next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_c      = 1'b0;
    add_c       = 1'b0;
    add_bias_c  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cfg_err_d   = cfg_hit_c && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          load_c  = 1'b1;
          idx_d   = IDX_W'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        if (accept_c) begin
          add_c = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_A - 1)) begin
            idx_d   = '0;
            state_d = BIAS;
          end
        end
      end
      BIAS: begin
        add_bias_c  = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = clamp(acc_next);
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
    end
  end

  // Coefficient/bias register file; writes land only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_A + 1; i++) begin
        coef_q[i] <= '0;
      end
    end else if (cfg_hit_c && (state_q == IDLE)) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  rw_svm_mac u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .add_i      (add_c),
    .add_bias_i (add_bias_c),
    .coef_i     (coef_q[idx_q]),
    .feat_i     (in_data),
    .bias_i     (coef_q[NUM_A]),
    .acc_next_o (acc_next)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rw_svm_seq_ctrl.sv
// Scoreboard bench for rw_svm_seq_ctrl: random vectors, config traffic and backpressure.
module tb_rw_svm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_data;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int coef_m[12];
  int acc_m = 0;
  int beat_m = 0;
  int fv[11];
  bit bp_rand = 1'b0;
  bit or_fix = 1'b1;

  always #5 clk = ~clk;

  rw_svm_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  function automatic int clamp_m(input int v);
    if (v < 0) return 0;
    if (v > 16383) return 16383;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: fixed level or random backpressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : or_fix;
    end
  end

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none", out_data);
      end else begin
        check("result", 32'(out_data), exp_q.pop_front());
      end
    end
  end

  // One feature beat, optionally with a config write in the same cycle.
  task automatic send_beat(input int f, input int gap, input bit we, input int waddr, input int wdata);
    bit rdy;
    bit accepted;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = 4'(f);
    if (we) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'(waddr);
      cfg_data = 8'(wdata);
    end
    accepted = 1'b0;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      rdy = in_ready;
      tick();
      cfg_we = 1'b0;
      if (rdy) accepted = 1'b1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_timeout: got no handshake expected handshake within 200 cycles");
      return;
    end
    if (beat_m == 0) acc_m = coef_m[0] * f;
    else acc_m += coef_m[beat_m] * f;
    if (we && waddr <= 11) coef_m[waddr] = wdata;
    beat_m++;
    if (beat_m == 11) begin
      exp_q.push_back(clamp_m(acc_m + coef_m[11]));
      beat_m = 0;
      @(negedge clk);
      check("bias_cycle_out_valid", 32'(out_valid), 0);
      check("bias_cycle_in_ready", 32'(in_ready), 0);
      check("bias_cycle_busy", 32'(busy), 1);
      tick();
      @(negedge clk);
      check("out_valid_latency", 32'(out_valid), 1);
      tick();
    end
  endtask

  task automatic send_vec(input int gapmax);
    for (int i = 0; i < 11; i++) begin
      send_beat(fv[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0, 1'b0, 0, 0);
    end
  endtask

  // Config write with the reject pulse predicted from the bench's own idea of idleness.
  task automatic cfg_write(input int addr, input int data);
    bit idle;
    bit inrange;
    idle    = (beat_m == 0) && (exp_q.size() == 0);
    inrange = (addr <= 11);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = 8'(data);
    tick();
    cfg_we = 1'b0;
    if (idle && inrange) coef_m[addr] = data;
    @(negedge clk);
    check("cfg_err", 32'(cfg_err), int'(!idle && inrange));
    tick();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && beat_m == 0) break;
      tick();
    end
    if (k == 400) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
    end
    tick();
  endtask

  task automatic load_coefs(input int c, input int b);
    wait_idle();
    for (int a = 0; a < 11; a++) cfg_write(a, c);
    cfg_write(11, b);
  endtask

  task automatic fill_fv(input int v);
    for (int i = 0; i < 11; i++) fv[i] = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 12; i++) coef_m[i] = 0;

    // Reset held 3 cycles with in_valid asserted.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'hf;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_cfg_err", 32'(cfg_err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_busy", 32'(busy), 0);
    tick();

    // Nominal: unit coefficients, all-15 features.
    load_coefs(1, 0);
    fill_fv(15);
    send_vec(0);
    wait_idle();

    // Write during ACC is rejected; out-of-range address is silent.
    for (int i = 0; i < 5; i++) send_beat(15, 0, 1'b0, 0, 0);
    cfg_write(0, 5);
    cfg_write(12, 3);
    for (int i = 5; i < 11; i++) send_beat(15, 0, 1'b0, 0, 0);
    wait_idle();
    cfg_write(0, 5);
    send_vec(0);
    wait_idle();

    // Clamp low.
    load_coefs(0, 0);
    cfg_write(0, -128);
    for (int i = 0; i < 11; i++) fv[i] = $urandom_range(0, 15);
    fv[0] = 15;
    send_vec(0);
    wait_idle();

    // Clamp high.
    load_coefs(127, 127);
    fill_fv(15);
    send_vec(0);
    wait_idle();

    // Idle gaps between beats.
    load_coefs(1, 0);
    send_vec(3);
    wait_idle();

    // Hold the result with out_ready low for 5 cycles.
    or_fix = 1'b0;
    send_vec(0);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_data", 32'(out_data), (exp_q.size() > 0) ? exp_q[0] : -1);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    cfg_write(3, 9);
    or_fix = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready", 32'(in_ready), 1);
    check("release_busy", 32'(busy), 0);
    tick();
    wait_idle();

    // Write coinciding with the first beat: feature 0 still sees the old coefficient.
    fill_fv(15);
    send_beat(15, 0, 1'b1, 0, -2);
    for (int i = 1; i < 11; i++) send_beat(15, 0, 1'b0, 0, 0);
    wait_idle();
    send_vec(0);
    wait_idle();

    // Randomized vectors, config traffic and backpressure.
    bp_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < 11; i++) fv[i] = $urandom_range(0, 15);
      send_vec(int'($urandom_range(0, 2)));
    end
    bp_rand = 1'b0;
    wait_idle();

    // Reset mid-vector after 5 beats clears coefficients.
    load_coefs(3, 1);
    for (int i = 0; i < 5; i++) send_beat(int'($urandom_range(0, 15)), 0, 1'b0, 0, 0);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) coef_m[i] = 0;
    beat_m = 0;
    acc_m  = 0;
    exp_q.delete();
    tick();
    for (int i = 0; i < 11; i++) fv[i] = $urandom_range(0, 15);
    send_vec(0);
    wait_idle();
    load_coefs(2, -5);
    for (int i = 0; i < 11; i++) fv[i] = $urandom_range(0, 15);
    send_vec(1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
